conv_window_ctrl: RTL and testbench

- Parametrised control FSM for the finger-vein sliding-window (convolution) datapath.
- Streams pixels of an IMG_W x IMG_H raster into the line/window buffer and tracks raster position itself, replacing the external "filled" flag.
- Fires the multiplier array for a configurable latency and writes each valid-window result with output back-pressure.
- Sits between the pixel source / line buffer and the MAC array / result memory.

---
 rtl/conv_window_ctrl.sv | 157 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: control FSM for the sliding-window convolution datapath.
// Streams an IMG_W x IMG_H raster into the window buffer and tracks the
// raster position. For every valid window it enables the MAC array for
// CAL_LAT cycles, then writes the result with sink back-pressure.
// Optional build macro: CONV_CTRL_STALL_CNT_EN adds a saturating stall_cnt output.
module conv_window_ctrl #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int WIN     = 3,
  parameter int CAL_LAT = 1,
  parameter int XW      = 6,
  parameter int YW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  output logic          pushpixel,
  output logic          multi_act,
  output logic          writepixel,
  input  logic          wr_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          busy,
  output logic          done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int CW = (CAL_LAT > 1) ? $clog2(CAL_LAT) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_TRIG  = XW'(WIN - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_TRIG  = YW'(WIN - 1);
  localparam logic [CW-1:0] CAL_END = CW'(CAL_LAT - 1);

  typedef enum logic [2:0] {IDLE, PUSH, CAL, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] cal_q;
  logic          last_q;   // the most recently pushed pixel was the frame's last
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic          kill;
  logic          xfer;
  logic          trig;

  // Abort only acts on a running frame; it overrides every other transition.
  assign kill = abort && (state_q != IDLE);
  assign xfer = (state_q == PUSH) && pix_valid;
  // Window is complete once the pixel at or beyond (WIN-1, WIN-1) lands.
  assign trig = xfer && (x_q >= X_TRIG) && (y_q >= Y_TRIG);

  assign busy  = (state_q != IDLE);
  assign out_x = ox_q;
  assign out_y = oy_q;

  // State register.
  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    pushpixel  = 1'b0;
    multi_act  = 1'b0;
    writepixel = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = PUSH;
      PUSH: begin
        pushpixel = 1'b1;
        if (trig) state_d = CAL;
      end
      CAL: begin
        multi_act = 1'b1;
        if (cal_q == CAL_END) state_d = WRITE;
      end
      WRITE: begin
        writepixel = 1'b1;
        if (wr_ready) state_d = last_q ? DONE : PUSH;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Raster counters, CAL latency counter and latched result coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || kill) begin
      x_q    <= '0;
      y_q    <= '0;
      cal_q  <= '0;
      last_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          x_q    <= '0;
          y_q    <= '0;
          last_q <= 1'b0;
        end
        PUSH: if (pix_valid) begin
          last_q <= (x_q == X_LAST) && (y_q == Y_LAST);
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
          if (trig) begin
            ox_q  <= x_q - X_TRIG;
            oy_q  <= y_q - Y_TRIG;
            cal_q <= '0;
          end
        end
        CAL: cal_q <= (cal_q == CAL_END) ? '0 : cal_q + CW'(1);
        DONE: begin
          x_q    <= '0;
          y_q    <= '0;
          last_q <= 1'b0;
          ox_q   <= '0;
          oy_q   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  // Saturating count of cycles lost to upstream starvation or sink back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (((state_q == PUSH) && !pix_valid) || ((state_q == WRITE) && !wr_ready)) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on a 4x4 image with a 3x3 window.
// Main instance uses CAL_LAT=1; a second instance uses CAL_LAT=3.
module tb_conv_window_ctrl;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int WIN   = 3;
  localparam int XW    = 6;
  localparam int YW    = 6;

  typedef struct {int x; int y;} coord_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, pix_valid = 1'b1, wr_ready = 1'b1;
  logic pushpixel, multi_act, writepixel, busy, done;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  logic start3 = 1'b0, abort3 = 1'b0, pix_valid3 = 1'b1, wr_ready3 = 1'b1;
  logic pushpixel3, multi_act3, writepixel3, busy3, done3;
  logic [XW-1:0] out_x3;
  logic [YW-1:0] out_y3;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt3;
`endif

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .CAL_LAT(1), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pix_valid(pix_valid),
    .pushpixel(pushpixel), .multi_act(multi_act), .writepixel(writepixel),
    .wr_ready(wr_ready), .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .CAL_LAT(3), .XW(XW), .YW(YW)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .pix_valid(pix_valid3),
    .pushpixel(pushpixel3), .multi_act(multi_act3), .writepixel(writepixel3),
    .wr_ready(wr_ready3), .out_x(out_x3), .out_y(out_y3), .busy(busy3), .done(done3)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed result coordinates for a 4x4 image / 3x3 window.
  int exp_x[4] = '{0, 1, 0, 1};
  int exp_y[4] = '{0, 0, 1, 1};
  coord_t q[$];
  coord_t q3[$];

  // Monitor state for the main instance.
  int cyc = 0, push_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int t11 = 0, last_wr_cyc = 0;
  bit first_rise_seen = 1'b0;
  logic wp_prev = 1'b0;

  // Main monitor: counts transfers, checks latency, pops scoreboard on writes.
  initial forever begin
    coord_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (pushpixel && pix_valid) begin
        push_cnt++;
        if (push_cnt == 11) t11 = cyc;
      end
      if (writepixel && !wp_prev && !first_rise_seen) begin
        first_rise_seen = 1'b1;
        check("first_write_latency", 32'(cyc - t11), 2);
      end
      if (writepixel && wr_ready) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("write_queued", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("out_x", 32'(out_x), 32'(e.x));
          check("out_y", 32'(out_y), 32'(e.y));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_write", 32'(cyc - last_wr_cyc), 1);
      end
    end
    wp_prev = writepixel;
  end

  // Monitor for the CAL_LAT=3 instance: CAL run length, coordinate stability, scoreboard.
  int run3 = 0, cal_runs3 = 0, wr3_cnt = 0, done3_cnt = 0;
  logic [XW-1:0] cx3 = '0;
  logic [YW-1:0] cy3 = '0;
  initial forever begin
    coord_t e;
    @(negedge clk);
    if (!rst) begin
      if ((multi_act3 && run3 > 0) || writepixel3) begin
        check("cal3_x_stable", 32'(out_x3), 32'(cx3));
        check("cal3_y_stable", 32'(out_y3), 32'(cy3));
      end
      if (multi_act3) begin
        if (run3 == 0) begin
          cx3 = out_x3;
          cy3 = out_y3;
        end
        run3++;
      end else if (run3 > 0) begin
        check("cal3_run_len", 32'(run3), 3);
        cal_runs3++;
        run3 = 0;
      end
      if (writepixel3 && wr_ready3) begin
        wr3_cnt++;
        check("write3_queued", 32'(q3.size() > 0), 1);
        if (q3.size() > 0) begin
          e = q3.pop_front();
          check("out_x3", 32'(out_x3), 32'(e.x));
          check("out_y3", 32'(out_y3), 32'(e.y));
        end
      end
      if (done3) done3_cnt++;
    end
  end

  task automatic expect_frame();
    for (int i = 0; i < 4; i++) q.push_back('{exp_x[i], exp_y[i]});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (wr_cnt < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(wr_cnt >= target), 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(done_cnt >= target), 1);
  endtask

  // which: 0 = writepixel, 1 = multi_act, 2 = done. Returns on the negedge it is seen.
  task automatic wait_high(input int which, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? writepixel : (which == 1) ? multi_act : done;
    end
    check(name, 32'(hit), 1);
  endtask

  task automatic frame_end(input int bp, input int bw, input int bd, input int ew);
    repeat (3) @(posedge clk);
    #1;
    check("frame_busy_low", 32'(busy), 0);
    check("frame_pushes", 32'(push_cnt - bp), 16);
    check("frame_writes", 32'(wr_cnt - bw), 32'(ew));
    check("frame_dones", 32'(done_cnt - bd), 1);
    check("frame_queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    int bp, bw, bd, k, n;
    logic [0:3] pat;
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp, bw, bd, k, n;
    logic [0:3] pat;
    pat = 4'b1001;

    // Reset state.
    #3;
    check("rst_outputs", 32'({pushpixel, multi_act, writepixel, busy, done}), 0);
    check("rst_coords", 32'({out_x, out_y}), 0);
`ifdef CONV_CTRL_STALL_CNT_EN
    check("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Nominal frame.
    bp = push_cnt; bw = wr_cnt; bd = done_cnt;
    expect_frame();
    pulse_start();
    wait_done(bd + 1, "nominal_done");
    check("nominal_idle_after_done", 32'(busy), 0);
    frame_end(bp, bw, bd, 4);

    // Back-pressure on the 2nd write: 5 stalled cycles, held 6 cycles.
    bp = push_cnt; bw = wr_cnt; bd = done_cnt;
    expect_frame();
    pulse_start();
    wait_writes(bw + 1, "bp_first_write");
    wr_ready = 1'b0;
    wait_high(0, "bp_second_write_seen");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 32'({writepixel, pushpixel, out_x, out_y}), 32'({1'b1, 1'b0, 6'd1, 6'd0}));
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 wr_ready = 1'b1;
    @(negedge clk);
    check("bp_hold_last", 32'({writepixel, pushpixel, out_x, out_y}), 32'({1'b1, 1'b0, 6'd1, 6'd0}));
    wait_done(bd + 1, "bp_done");
    frame_end(bp, bw, bd, 4);
`ifdef CONV_CTRL_STALL_CNT_EN
    check("bp_stall_cnt", 32'(stall_cnt), 5);
`endif

    // Upstream stall: pix_valid pattern 1,0,0,1 repeated.
    bp = push_cnt; bw = wr_cnt; bd = done_cnt;
    expect_frame();
    pulse_start();
    k = 0;
    n = 0;
    while (done_cnt < bd + 1 && n < 400) begin
      pix_valid = pat[k % 4];
      k++;
      n++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    check("stall_done", 32'(done_cnt >= bd + 1), 1);
    frame_end(bp, bw, bd, 4);

    // Abort during the 2nd CAL.
    bw = wr_cnt; bd = done_cnt;
    q.push_back('{0, 0});
    pulse_start();
    wait_writes(bw + 1, "abort_first_write");
    wait_high(1, "abort_second_cal_seen");
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({busy, multi_act, writepixel, pushpixel}), 0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_more_writes", 32'(wr_cnt - bw), 1);
    check("abort_no_done", 32'(done_cnt - bd), 0);
    check("abort_queue_empty", 32'(q.size()), 0);

    // Restart begins at (0,0); then rst mid-WRITE.
    bw = wr_cnt; bd = done_cnt;
    q.push_back('{0, 0});
    pulse_start();
    wait_writes(bw + 1, "restart_first_write");
    wr_ready = 1'b0;
    wait_high(0, "rst_write_seen");
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({pushpixel, multi_act, writepixel, busy, done}), 0);
    check("rst_mid_coords", 32'({out_x, out_y}), 0);
    @(posedge clk); #1 rst = 1'b0;
    wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_partial_write", 32'(wr_cnt - bw), 1);
    check("rst_no_done", 32'(done_cnt - bd), 0);
    check("rst_idle", 32'(busy), 0);

    // start while busy is ignored.
    bp = push_cnt; bw = wr_cnt; bd = done_cnt;
    expect_frame();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(bd + 1, "busy_start_done");
    repeat (10) @(posedge clk);
    frame_end(bp, bw, bd, 4);

    // start held through DONE: new frame begins on the IDLE cycle.
    bw = wr_cnt;
    expect_frame();
    @(posedge clk); #1 start = 1'b1;
    wait_high(2, "held_done_seen");
    @(negedge clk);
    check("held_idle_cycle", 32'(busy), 0);
    @(negedge clk);
    check("held_restart", 32'({busy, pushpixel}), 3);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_abort_idle", 32'(busy), 0);
    check("held_writes", 32'(wr_cnt - bw), 4);
    check("held_queue_empty", 32'(q.size()), 0);

    // CAL_LAT=3 instance.
    for (int i = 0; i < 4; i++) q3.push_back('{exp_x[i], exp_y[i]});
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    n = 0;
    while (done3_cnt < 1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("cal3_done", 32'(done3_cnt), 1);
    repeat (3) @(posedge clk);
    #1;
    check("cal3_writes", 32'(wr3_cnt), 4);
    check("cal3_runs", 32'(cal_runs3), 4);
    check("cal3_queue_empty", 32'(q3.size()), 0);
    check("cal3_idle", 32'(busy3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
